// File: rtl/manual_drive_if.sv
// Operator-switch inputs and registered drive outputs of the manual drive controller.
interface manual_drive_if #(
    parameter int unsigned MILE_W = 24
);
    logic              power_btn;
    logic              mode_manual;
    logic              throttle;
    logic              clutch;
    logic              brake;
    logic              reverse;
    logic              turn_left;
    logic              turn_right;
    logic              power_state;
    logic [1:0]        drive_state;
    logic              move_forward_signal;
    logic              move_backward_signal;
    logic              turn_left_signal;
    logic              turn_right_signal;
    logic              turn_left_light;
    logic              turn_right_light;
    logic [MILE_W-1:0] mileage;

    modport master (
        output power_btn, mode_manual, throttle, clutch, brake, reverse, turn_left, turn_right,
        input  power_state, drive_state, move_forward_signal, move_backward_signal,
               turn_left_signal, turn_right_signal, turn_left_light, turn_right_light, mileage
    );

    modport slave (
        input  power_btn, mode_manual, throttle, clutch, brake, reverse, turn_left, turn_right,
        output power_state, drive_state, move_forward_signal, move_backward_signal,
               turn_left_signal, turn_right_signal, turn_left_light, turn_right_light, mileage
    );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Power-button handling, manual drive FSM, turn-light blinker and odometer.
module manual_drive_ctrl #(
    parameter int unsigned POWER_HOLD_CYCLES = 100_000_000,
    parameter int unsigned BLINK_HALF_CYCLES = 50_000_000,
    parameter int unsigned MILE_TICK_CYCLES  = 100_000_000,
    parameter int unsigned MILE_W            = 24
) (
    input  logic          clk,
    input  logic          rst,
    manual_drive_if.slave bus
);
    localparam logic [1:0] NOT_STARTING = 2'b00;
    localparam logic [1:0] STARTING     = 2'b01;
    localparam logic [1:0] MOVING       = 2'b10;

    localparam int unsigned HOLD_W  = (POWER_HOLD_CYCLES > 1) ? $clog2(POWER_HOLD_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam int unsigned MCNT_W  = (MILE_TICK_CYCLES > 1) ? $clog2(MILE_TICK_CYCLES) : 1;

    logic               power_q, power_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               arm_q, arm_d;
    logic [1:0]         drive_q, drive_d;
    logic               reverse_q;
    logic               move_fwd_q, move_fwd_d;
    logic               move_bwd_q, move_bwd_d;
    logic               tl_sig_q, tl_sig_d;
    logic               tr_sig_q, tr_sig_d;
    logic               tl_light_q, tl_light_d;
    logic               tr_light_q, tr_light_d;
    logic [BLINK_W-1:0] blink_l_q, blink_l_d;
    logic [BLINK_W-1:0] blink_r_q, blink_r_d;
    logic [MCNT_W-1:0]  mile_cnt_q, mile_cnt_d;
    logic [MILE_W-1:0]  mileage_q, mileage_d;
    logic               stall;
    logic               power_on;
    logic               power_off;

    // State register for all controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            power_q    <= 1'b0;
            hold_q     <= '0;
            arm_q      <= 1'b0;
            drive_q    <= NOT_STARTING;
            reverse_q  <= 1'b0;
            move_fwd_q <= 1'b0;
            move_bwd_q <= 1'b0;
            tl_sig_q   <= 1'b0;
            tr_sig_q   <= 1'b0;
            tl_light_q <= 1'b0;
            tr_light_q <= 1'b0;
            blink_l_q  <= '0;
            blink_r_q  <= '0;
            mile_cnt_q <= '0;
            mileage_q  <= '0;
        end else begin
            power_q    <= power_d;
            hold_q     <= hold_d;
            arm_q      <= arm_d;
            drive_q    <= drive_d;
            reverse_q  <= bus.reverse;
            move_fwd_q <= move_fwd_d;
            move_bwd_q <= move_bwd_d;
            tl_sig_q   <= tl_sig_d;
            tr_sig_q   <= tr_sig_d;
            tl_light_q <= tl_light_d;
            tr_light_q <= tr_light_d;
            blink_l_q  <= blink_l_d;
            blink_r_q  <= blink_r_d;
            mile_cnt_q <= mile_cnt_d;
            mileage_q  <= mileage_d;
        end
    end

    // Next-state: power sequencing, stall detection, drive FSM, odometer and blink.
    always_comb begin
        power_d    = power_q;
        hold_d     = hold_q;
        arm_d      = arm_q;
        drive_d    = NOT_STARTING;
        mile_cnt_d = mile_cnt_q;
        mileage_d  = mileage_q;
        blink_l_d  = blink_l_q;
        blink_r_d  = blink_r_q;
        tl_light_d = tl_light_q;
        tr_light_d = tr_light_q;
        stall      = 1'b0;
        power_on   = 1'b0;
        power_off  = 1'b0;

        // Odometer runs on the cycle the car is already moving.
        if (drive_q == MOVING) begin
            if (mile_cnt_q == MCNT_W'(MILE_TICK_CYCLES - 1)) begin
                mile_cnt_d = '0;
                if (mileage_q != {MILE_W{1'b1}}) begin
                    mileage_d = mileage_q + MILE_W'(1);
                end
            end else begin
                mile_cnt_d = mile_cnt_q + MCNT_W'(1);
            end
        end

        if (!power_q) begin
            if (!bus.power_btn) begin
                hold_d = '0;
            end else if (hold_q == HOLD_W'(POWER_HOLD_CYCLES - 1)) begin
                power_on = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            hold_d = '0;
            if (bus.mode_manual) begin
                case (drive_q)
                    NOT_STARTING: stall = bus.throttle & ~bus.clutch & ~bus.brake;
                    MOVING:       stall = (bus.reverse != reverse_q) & ~bus.clutch;
                    default:      stall = 1'b0;
                endcase
            end
            power_off = (bus.power_btn & arm_q) | stall;
            if (!bus.power_btn) begin
                arm_d = 1'b1;
            end
            if (!power_off && bus.mode_manual) begin
                case (drive_q)
                    NOT_STARTING: drive_d = (bus.throttle & bus.clutch & ~bus.brake) ? STARTING : NOT_STARTING;
                    STARTING: begin
                        if (bus.brake)                        drive_d = NOT_STARTING;
                        else if (bus.throttle && !bus.clutch) drive_d = MOVING;
                        else                                  drive_d = STARTING;
                    end
                    MOVING: begin
                        if (bus.brake)                        drive_d = NOT_STARTING;
                        else if (bus.clutch || !bus.throttle) drive_d = STARTING;
                        else                                  drive_d = MOVING;
                    end
                    default: drive_d = NOT_STARTING;
                endcase
            end
        end

        if (power_on) begin
            power_d   = 1'b1;
            hold_d    = '0;
            arm_d     = 1'b0;
            mileage_d = '0;
        end
        if (power_off) begin
            power_d = 1'b0;
            hold_d  = '0;
            arm_d   = 1'b0;
        end

        move_fwd_d = (drive_d == MOVING) & ~bus.reverse;
        move_bwd_d = (drive_d == MOVING) & bus.reverse;
        tl_sig_d   = power_d & bus.mode_manual & bus.turn_left & ~bus.turn_right;
        tr_sig_d   = power_d & bus.mode_manual & bus.turn_right & ~bus.turn_left;

        // Left blinker: light on at request, toggles each half period, off when dropped.
        if (tl_sig_d && !tl_sig_q) begin
            tl_light_d = 1'b1;
            blink_l_d  = '0;
        end else if (tl_sig_d) begin
            if (blink_l_q == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
                tl_light_d = ~tl_light_q;
                blink_l_d  = '0;
            end else begin
                blink_l_d = blink_l_q + BLINK_W'(1);
            end
        end else begin
            tl_light_d = 1'b0;
            blink_l_d  = '0;
        end

        // Right blinker, mirror of the left one.
        if (tr_sig_d && !tr_sig_q) begin
            tr_light_d = 1'b1;
            blink_r_d  = '0;
        end else if (tr_sig_d) begin
            if (blink_r_q == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
                tr_light_d = ~tr_light_q;
                blink_r_d  = '0;
            end else begin
                blink_r_d = blink_r_q + BLINK_W'(1);
            end
        end else begin
            tr_light_d = 1'b0;
            blink_r_d  = '0;
        end
    end

    assign bus.power_state          = power_q;
    assign bus.drive_state          = drive_q;
    assign bus.move_forward_signal  = move_fwd_q;
    assign bus.move_backward_signal = move_bwd_q;
    assign bus.turn_left_signal     = tl_sig_q;
    assign bus.turn_right_signal    = tr_sig_q;
    assign bus.turn_left_light      = tl_light_q;
    assign bus.turn_right_light     = tr_light_q;
    assign bus.mileage              = mileage_q;
endmodule
